// File: rtl/lsu_instr_sequencer_if.sv
// rtl/lsu_instr_sequencer_if.sv - instruction valid/ready port between sequencer and shim
interface lsu_instr_sequencer_if;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    modport master (
        output instr_o,
        output instr_valid_o,
        input  instr_ready_i
    );

    modport slave (
        input  instr_o,
        input  instr_valid_o,
        output instr_ready_i
    );
endinterface

// File: rtl/lsu_instr_sequencer.sv
// rtl/lsu_instr_sequencer.sv - in-order program issuer with bubbles after memory ops
module lsu_instr_sequencer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int MEM_GAP = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     prog_we_i,
    input  logic [AW-1:0]            prog_waddr_i,
    input  logic [31:0]              prog_wdata_i,
    input  logic                     start_i,
    input  logic [AW:0]              prog_len_i,
    lsu_instr_sequencer_if.master    instr_if,
    output logic [AW:0]              pc_o,
    output logic [AW:0]              issued_o,
    output logic                     mem_op_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [2:0]  GAP_INIT = 3'(MEM_GAP);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    state_t      state_q, state_n;
    logic [AW:0] pc_q, pc_n;
    logic [AW:0] issued_q, issued_n;
    logic [AW:0] len_q, len_n;
    logic [2:0]  gap_q, gap_n;
    logic [31:0] prog_mem [DEPTH];

    logic [AW:0] len_clamped;
    logic [AW:0] pc_inc;
    logic [31:0] cur_word;
    logic        valid;
    logic        handshake;
    logic        prog_ok;

    assign len_clamped = (prog_len_i > DEPTH_W) ? DEPTH_W : prog_len_i;
    assign pc_inc      = pc_q + (AW+1)'(1);
    assign prog_ok     = (state_q == S_IDLE) || (state_q == S_DONE);

    // pc stays below len while in ISSUE, so the low AW bits always address a valid slot
    assign cur_word  = prog_mem[pc_q[AW-1:0]];
    assign valid     = (state_q == S_ISSUE);
    assign handshake = valid && instr_if.instr_ready_i;

    assign instr_if.instr_valid_o = valid;
    assign instr_if.instr_o       = valid ? cur_word : 32'd0;
    assign mem_op_o = valid && ((cur_word[6:0] == OP_LOAD) || (cur_word[6:0] == OP_STORE));
    assign busy_o   = (state_q == S_ISSUE) || (state_q == S_GAP);
    assign done_o   = (state_q == S_DONE);
    assign pc_o     = pc_q;
    assign issued_o = issued_q;

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        issued_n = issued_q;
        len_n    = len_q;
        gap_n    = gap_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    len_n    = len_clamped;
                    pc_n     = '0;
                    issued_n = '0;
                    state_n  = (len_clamped == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    pc_n     = pc_inc;
                    issued_n = issued_q + (AW+1)'(1);
                    if (pc_inc == len_q) begin
                        state_n = S_DONE;
                    end else if (mem_op_o && (MEM_GAP > 0)) begin
                        state_n = S_GAP;
                        gap_n   = GAP_INIT;
                    end
                end
            end
            S_GAP: begin
                gap_n = gap_q - 3'd1;
                if (gap_q <= 3'd1) begin
                    state_n = S_ISSUE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            issued_q <= '0;
            len_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            issued_q <= issued_n;
            len_q    <= len_n;
            gap_q    <= gap_n;
        end
    end

    // program contents survive reset so a restart reissues the same words
    always_ff @(posedge clk_i) begin
        if (prog_we_i && prog_ok) begin
            prog_mem[prog_waddr_i] <= prog_wdata_i;
        end
    end

endmodule

// File: tb/tb_lsu_instr_sequencer.sv
// tb/tb_lsu_instr_sequencer.sv - table-driven bench for lsu_instr_sequencer with lockstep pair
module tb_lsu_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    localparam logic [31:0] ADDI  = 32'h00000093;
    localparam logic [31:0] LW0   = 32'h00002083;
    localparam logic [31:0] SW1   = 32'h00102023;
    localparam logic [31:0] LW2   = 32'h00402103;
    localparam logic [31:0] LW3   = 32'h00802183;
    localparam logic [31:0] LWS   = 32'h00c02283;
    localparam logic [31:0] JUNK  = 32'hdeadbeef;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_waddr = '0;
    logic [31:0]   prog_wdata = '0;
    logic          start = 1'b0;
    logic [AW:0]   prog_len = '0;
    logic          ready = 1'b0;

    logic [AW:0] pc_a, pc_b, issued_a, issued_b;
    logic        mem_a, mem_b, busy_a, busy_b, done_a, done_b;

    lsu_instr_sequencer_if ifa ();
    lsu_instr_sequencer_if ifb ();
    assign ifa.instr_ready_i = ready;
    assign ifb.instr_ready_i = ready;

    lsu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .MEM_GAP(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .prog_we_i(prog_we), .prog_waddr_i(prog_waddr),
        .prog_wdata_i(prog_wdata), .start_i(start), .prog_len_i(prog_len),
        .instr_if(ifa.master), .pc_o(pc_a), .issued_o(issued_a),
        .mem_op_o(mem_a), .busy_o(busy_a), .done_o(done_a)
    );

    lsu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .MEM_GAP(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .prog_we_i(prog_we), .prog_waddr_i(prog_waddr),
        .prog_wdata_i(prog_wdata), .start_i(start), .prog_len_i(prog_len),
        .instr_if(ifb.master), .pc_o(pc_b), .issued_o(issued_b),
        .mem_op_o(mem_b), .busy_o(busy_b), .done_o(done_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        we;
        logic        valid;
        logic [31:0] instr;
        logic [2:0]  pc;
        logic        mem;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [18];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic w, logic v, logic [31:0] i, logic [2:0] p,
                                logic m, logic b, logic d);
        vec_t x;
        x.ready = r; x.we = w; x.valid = v; x.instr = i; x.pc = p;
        x.mem = m; x.busy = b; x.done = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_slot(input logic [AW-1:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_waddr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_start(input logic [AW:0] l);
        start = 1'b1; prog_len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_lockstep(input string tag);
        chk({tag, "_ls_valid"}, {31'd0, ifb.instr_valid_o}, {31'd0, ifa.instr_valid_o});
        chk({tag, "_ls_instr"}, ifb.instr_o, ifa.instr_o);
        chk({tag, "_ls_pc"}, {29'd0, pc_b}, {29'd0, pc_a});
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] i,
                             input logic [2:0] p, input logic m, input logic b, input logic d);
        chk({tag, "_valid"},  {31'd0, ifa.instr_valid_o}, {31'd0, v});
        chk({tag, "_instr"},  ifa.instr_o, i);
        chk({tag, "_pc"},     {29'd0, pc_a}, {29'd0, p});
        chk({tag, "_issued"}, {29'd0, issued_a}, {29'd0, p});
        chk({tag, "_mem"},    {31'd0, mem_a}, {31'd0, m});
        chk({tag, "_busy"},   {31'd0, busy_a}, {31'd0, b});
        chk({tag, "_done"},   {31'd0, done_a}, {31'd0, d});
        chk_lockstep(tag);
    endtask

    task automatic run_rows(input string tag, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            ready      = tbl[k].ready;
            prog_we    = tbl[k].we;
            prog_waddr = 2'd3;
            prog_wdata = JUNK;
            #1;
            chk_state($sformatf("%s_r%0d", tag, k), tbl[k].valid, tbl[k].instr, tbl[k].pc,
                      tbl[k].mem, tbl[k].busy, tbl[k].done);
            tick();
            prog_we = 1'b0;
        end
    endtask

    initial begin
        int          n_issue;
        logic [31:0] words [4];

        // ADDI run: four back-to-back issues, then DONE
        tbl[0]  = mk(1, 0, 1, ADDI, 3'd0, 0, 1, 0);
        tbl[1]  = mk(1, 0, 1, ADDI, 3'd1, 0, 1, 0);
        tbl[2]  = mk(1, 0, 1, ADDI, 3'd2, 0, 1, 0);
        tbl[3]  = mk(1, 0, 1, ADDI, 3'd3, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 32'd0, 3'd4, 0, 0, 1);
        // LW,SW,LW,LW with one bubble after each memory op; write in GAP must be ignored
        tbl[5]  = mk(1, 0, 1, LW0, 3'd0, 1, 1, 0);
        tbl[6]  = mk(1, 1, 0, 32'd0, 3'd1, 0, 1, 0);
        tbl[7]  = mk(1, 0, 1, SW1, 3'd1, 1, 1, 0);
        tbl[8]  = mk(1, 0, 0, 32'd0, 3'd2, 0, 1, 0);
        tbl[9]  = mk(1, 0, 1, LW2, 3'd2, 1, 1, 0);
        tbl[10] = mk(1, 1, 0, 32'd0, 3'd3, 0, 1, 0);
        tbl[11] = mk(1, 0, 1, LW3, 3'd3, 1, 1, 0);
        tbl[12] = mk(1, 0, 0, 32'd0, 3'd4, 0, 0, 1);
        // single LW stalled by ready=0 for three cycles
        tbl[13] = mk(0, 0, 1, LWS, 3'd0, 1, 1, 0);
        tbl[14] = mk(0, 0, 1, LWS, 3'd0, 1, 1, 0);
        tbl[15] = mk(0, 0, 1, LWS, 3'd0, 1, 1, 0);
        tbl[16] = mk(1, 0, 1, LWS, 3'd0, 1, 1, 0);
        tbl[17] = mk(1, 0, 0, 32'd0, 3'd1, 0, 0, 1);

        do_reset();
        chk_state("reset", 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);

        for (int s = 0; s < DEPTH; s++) write_slot(AW'(s), ADDI);
        do_start(3'd4);
        run_rows("addi", 0, 4);

        write_slot(2'd0, LW0);
        write_slot(2'd1, SW1);
        write_slot(2'd2, LW2);
        write_slot(2'd3, LW3);
        do_start(3'd4);
        run_rows("memgap", 5, 12);

        // reset while in GAP after the second issue, then restart from retained buffer
        do_start(3'd4);
        run_rows("pre_rst", 5, 7);
        chk("in_gap_busy", {31'd0, busy_a}, 32'd1);
        chk("in_gap_valid", {31'd0, ifa.instr_valid_o}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("midrst", 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        do_start(3'd4);
        run_rows("restart", 5, 12);

        // start together with a program write in IDLE issues the new word
        do_reset();
        prog_we = 1'b1; prog_waddr = 2'd0; prog_wdata = LWS;
        do_start(3'd1);
        prog_we = 1'b0;
        run_rows("stall", 13, 17);

        // len=0 goes straight to DONE; len=7 clamps to DEPTH
        do_reset();
        ready = 1'b1;
        do_start(3'd0);
        chk_state("len0", 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        words[0] = 32'h00100093; words[1] = 32'h00200093;
        words[2] = 32'h00300093; words[3] = 32'h00400093;
        for (int s = 0; s < DEPTH; s++) write_slot(AW'(s), words[s]);
        do_start(3'd7);
        n_issue = 0;
        for (int c = 0; c < 20 && !done_a; c++) begin
            if (ifa.instr_valid_o) begin
                chk($sformatf("clamp_instr%0d", n_issue), ifa.instr_o, words[n_issue % 4]);
                n_issue++;
            end
            chk_lockstep("clamp");
            tick();
        end
        chk("clamp_done", {31'd0, done_a}, 32'd1);
        chk("clamp_count", n_issue, 32'd4);
        chk("clamp_issued", {29'd0, issued_a}, 32'd4);
        chk("clamp_pc", {29'd0, pc_a}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
